// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter/mux with per-requester enable mask and a single registered output stage.
// Latency 1 cycle; the register reloads on the same edge it drains; in_ready is low while the output is stalled.
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         in_ready,
  input  logic [N-1:0]         enable_mask,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_ready
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] last;
  logic [SW-1:0] grant;
  logic          grant_vld;
  logic [N-1:0]  eligible;
  logic          out_free;
  logic          xfer;
  logic [W-1:0]  grant_data;

  assign eligible = in_valid & enable_mask;
  assign out_free = ~out_valid | out_ready;

  // Walk the search order backwards so the nearest eligible index after last is the one that sticks.
  always_comb begin
    int idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last) + i) % N;
      if (eligible[idx]) begin
        grant     = idx[SW-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  assign xfer       = grant_vld & out_free & ~rst;
  assign grant_data = in_data[int'(grant)*W +: W];

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      last      <= SW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_src   <= grant;
      last      <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_rr_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   enable_mask;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  int          m_last;
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_src;
  logic [N-1:0] obs_ready;

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .enable_mask(enable_mask), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; advances one clock.
  task automatic cycle();
    int g;
    bit free;
    logic [N-1:0] exp_ready;
    #1;
    g = -1;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (m_last + i) % N;
      if (g < 0 && in_valid[k] && enable_mask[k]) g = k;
    end
    free = !m_valid || out_ready;
    exp_ready = '0;
    if (!rst && free && g >= 0) exp_ready[g] = 1'b1;
    obs_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_src", 32'(out_src), 32'(m_src));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = '0; m_src = 0; m_last = N - 1;
    end else if (free && g >= 0) begin
      m_valid = 1; m_data = in_data[g*W +: W]; m_src = g; m_last = g;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int exp_src[$];
    logic [W-1:0] exp_dat[$];
    logic [W-1:0] held_data;
    logic [1:0]   held_src;

    rst = 1'b1; in_valid = '0; in_data = '0; enable_mask = '1; out_ready = 1'b0;
    m_last = N - 1; m_valid = 0; m_data = '0; m_src = 0;
    @(negedge clk);
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    rst = 1'b0;

    // alternating pair 0 and 2
    in_data = {8'hD0, 8'hC0, 8'hB0, 8'hA0};
    in_valid = 4'b0101; out_ready = 1'b1;
    exp_src = '{0, 2, 0, 2};
    exp_dat = '{8'hA0, 8'hC0, 8'hA0, 8'hC0};
    foreach (exp_src[i]) begin
      cycle();
      chk("alt_src", 32'(out_src), 32'(exp_src[i]));
      chk("alt_data", 32'(out_data), 32'(exp_dat[i]));
      chk("alt_valid", 32'(out_valid), 32'd1);
    end

    // all four valid, full rate rotation
    do_reset();
    in_valid = 4'b1111;
    exp_src = '{0, 1, 2, 3, 0};
    foreach (exp_src[i]) begin
      cycle();
      chk("rot_src", 32'(out_src), 32'(exp_src[i]));
      chk("rot_valid", 32'(out_valid), 32'd1);
    end

    // downstream stall for three cycles, then release
    held_data = out_data; held_src = out_src;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_ready", 32'(obs_ready), 32'd0);
      chk("stall_data", 32'(out_data), 32'(held_data));
      chk("stall_src", 32'(out_src), 32'(held_src));
    end
    out_ready = 1'b1;
    cycle();
    chk("release_src", 32'(out_src), 32'd1);
    chk("release_data", 32'(out_data), 32'hB0);

    // masked requester 1
    do_reset();
    enable_mask = 4'b1101;
    exp_src = '{0, 2, 3, 0};
    foreach (exp_src[i]) begin
      cycle();
      chk("mask_src", 32'(out_src), 32'(exp_src[i]));
    end

    // only requester 3: granted repeatedly, wrapping to itself
    in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("self_src", 32'(out_src), 32'd3);
      chk("self_valid", 32'(out_valid), 32'd1);
    end

    // mid-stream reset discards the held word
    enable_mask = 4'b1111;
    out_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    in_valid = 4'b0110;
    out_ready = 1'b1;
    cycle();
    chk("post_rst_src", 32'(out_src), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'hB0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      in_valid    = 4'($urandom);
      enable_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      in_data     = 32'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
